// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width and ALU-B operand source indices.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        SRC_REGB = 2'd0,
        SRC_DMEM = 2'd1,
        SRC_LIT  = 2'd2,
        SRC_ZERO = 2'd3
    } alu_b_src_e;

endpackage

// File: rtl/operand_sel_pipe_if.sv
// Upstream offer / downstream delivery signals of the operand selector.
interface operand_sel_pipe_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    oob_err;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid, oob_err
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid, oob_err
    );
endinterface

// File: rtl/operand_sel_pipe_skid_buf.sv
// Two-entry valid/ready register pair; in_ready is registered so it has no
// combinational path from out_ready.
module skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_payload,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_payload,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] main_q, main_n, skid_q, skid_n;
    logic         main_v_q, main_v_n, skid_v_q, skid_v_n;
    logic         rdy_q;
    logic         accept, drain;

    assign accept = in_valid && rdy_q;
    assign drain  = main_v_q && out_ready;

    always_comb begin
        main_n   = main_q;
        main_v_n = main_v_q;
        skid_n   = skid_q;
        skid_v_n = skid_v_q;
        if (!main_v_q || drain) begin
            // A full skid implies rdy_q was low, so no accept can collide here.
            if (skid_v_q) begin
                main_n   = skid_q;
                main_v_n = 1'b1;
                skid_v_n = 1'b0;
            end else begin
                main_v_n = accept;
                if (accept) main_n = in_payload;
            end
        end else if (accept) begin
            skid_n   = in_payload;
            skid_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            main_q   <= main_n;
            main_v_q <= main_v_n;
            skid_q   <= skid_n;
            skid_v_q <= skid_v_n;
            rdy_q    <= !skid_v_n;
        end
    end

    assign in_ready    = rdy_q;
    assign out_payload = main_q;
    assign out_valid   = main_v_q;
endmodule

// File: rtl/operand_sel_pipe.sv
// N-way operand selector feeding a registered skid-buffered output stage,
// with a sticky flag for out-of-range selects.
module operand_sel_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH    = DATA_W,
    parameter int unsigned NUM_IN   = 4,
    parameter bit          OOB_ZERO = 1'b1
) (
    input logic               clk,
    input logic               rst,
    operand_sel_pipe_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);
    localparam int unsigned PW    = WIDTH + SEL_W;

    logic [WIDTH-1:0] sel_data;
    logic [PW-1:0]    out_payload;
    logic             in_oob;
    logic             in_ready;
    logic             oob_q;

    always_comb begin
        sel_data = OOB_ZERO ? '0 : bus.in_data[0 +: WIDTH];
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) sel_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    // A full power-of-two select range has no out-of-range codes.
    generate
        if (NUM_IN == (1 << SEL_W)) begin : g_no_oob
            assign in_oob = 1'b0;
        end else begin : g_oob
            assign in_oob = 32'(bus.in_sel) >= 32'(NUM_IN);
        end
    endgenerate

    skid_buf #(
        .W (PW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_payload  ({sel_data, bus.in_sel}),
        .in_valid    (bus.in_valid),
        .in_ready    (in_ready),
        .out_payload (out_payload),
        .out_valid   (bus.out_valid),
        .out_ready   (bus.out_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_q <= 1'b0;
        end else if (bus.in_valid && in_ready && in_oob) begin
            oob_q <= 1'b1;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.out_data = out_payload[PW-1 -: WIDTH];
    assign bus.out_sel  = out_payload[SEL_W-1:0];
    assign bus.oob_err  = oob_q;
endmodule

// File: doc/operand_sel_pipe.md
Name: operand_sel_pipe

Overview:
- Parametrised N-way operand selector with a registered, flow-controlled output stage.
- Successor to the fixed 8-bit 4:1 ALU-B operand mux. Sits between the register file / data memory / literal sources and the ALU B input.
- Adds configurable width and input count, a defined out-of-range constant-zero path, and a valid/ready skid buffer so the execute stage can stall without losing a selected operand.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; localparam, not overridable.
- OOB_ZERO, 1, 1: select >= NUM_IN yields all-zero data; 0: yields input 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  source select, sampled with in_data.
- in_valid  in  1  upstream offers in_data/in_sel this cycle.
- in_ready  out  1  block can accept this cycle.
- out_data  out  WIDTH  selected operand.
- out_sel  out  SEL_W  select value that produced out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- oob_err  out  1  sticky flag: an accepted transfer carried in_sel >= NUM_IN.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_sel=0, out_valid=0, skid empty, oob_err=0. in_ready=0 while rst is high and 1 in the first cycle after release.
- Selection is combinational on the input side. sel_data = input[in_sel] if in_sel < NUM_IN. Otherwise it is 0 (OOB_ZERO=1) or input 0 (OOB_ZERO=0).
- Storage: main register (out_*) plus one skid register (skid_data, skid_sel, skid_valid).
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Accept occurs when in_valid && in_ready. Drain occurs when out_valid && out_ready.
- Per-cycle update, evaluated together:
  - Main empty or draining, skid empty: accepted data loads main; out_valid = accept.
  - Main draining, skid full: skid moves to main. in_ready was 0, so no accept this cycle. skid_valid clears.
  - Main full and not draining, accept: data loads skid; skid_valid=1, so in_ready drops next cycle.
- Latency: 1 cycle from accept to out_valid when not stalled. Throughput: 1 transfer/cycle sustained with out_ready held high.
- Ordering: strict FIFO, depth 2. Nothing is dropped or duplicated.
- out_data/out_sel must stay stable while out_valid && !out_ready.
- oob_err sets on any accepted transfer with in_sel >= NUM_IN and is cleared only by rst. When NUM_IN is a power of two it can never set.
- Reset mid-operation: both stages are discarded immediately. No transfer is reported after release until a new accept.
- Undefined in_sel bits (X) when in_valid=0 must not propagate into state.

Decomposition:
- Shared package (cpu_pkg): default DATA_W=8 and named source-index constants SRC_REGB=0, SRC_DMEM=1, SRC_LIT=2, SRC_ZERO=3 for the ALU-B instance.
- One natural sub-module: skid_buf, a WIDTH+SEL_W-wide 2-entry valid/ready register pair.
- The selector stays inline in operand_sel_pipe.

Test Plan:
- Reset: assert rst mid-stream with main and skid full -> out_valid=0, oob_err=0, out_data=0 immediately. in_ready=1 one cycle after release.
- Basic select (WIDTH=8, NUM_IN=4, out_ready=1): inputs {0x11,0x22,0x33,0x00}, in_sel=2, in_valid=1 -> next cycle out_valid=1, out_data=0x33, out_sel=2.
- Back-to-back stream of sel 0,1,2,3 with out_ready=1 -> outputs 0x11,0x22,0x33,0x00 on four consecutive cycles, no bubbles.
- Stall: out_ready=0 while sending sel 0 then sel 1 -> main holds 0x11, skid holds 0x22, in_ready=0. A third offer (sel 2) is not accepted. Raising out_ready gives 0x11 then 0x22 on consecutive cycles, then in_ready=1.
- Out-of-range (NUM_IN=3, OOB_ZERO=1): in_sel=3, inputs {0xA5,0x5A,0xFF} -> out_data=0x00 and oob_err=1, remaining set after subsequent legal transfers.
- OOB fallback (NUM_IN=3, OOB_ZERO=0): in_sel=3 -> out_data=0xA5 and oob_err=1.
